// File: rtl/mem_access_pkg.sv
// Shared definitions for the data-memory access unit: funct3 encodings,
// FSM state type and the request legality rule.
package mem_access_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        RESP = 2'd3
    } mau_state_t;

    // Unsigned variants exist only for loads; halfwords need even, words
    // need word-aligned addresses.
    function automatic logic req_legal(input logic we, input logic [2:0] funct3,
                                       input logic [1:0] offset);
        logic ok;
        case (funct3)
            F3_B:    ok = 1'b1;
            F3_BU:   ok = !we;
            F3_H:    ok = !offset[0];
            F3_HU:   ok = !we && !offset[0];
            F3_W:    ok = (offset == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mau_lane_align.sv
// Combinational lane logic: extracts and extends load data from a memory word,
// and merges sub-word store data into the old word for read-modify-write.
module mau_lane_align
    import mem_access_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] store_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word[{offset, 3'b000} +: 8];
        half_sel = word[{offset[1], 4'b0000} +: 16];

        case (funct3)
            F3_B:    load_data = 32'($signed(byte_sel));
            F3_BU:   load_data = {24'd0, byte_sel};
            F3_H:    load_data = 32'($signed(half_sel));
            F3_HU:   load_data = {16'd0, half_sel};
            default: load_data = word;
        endcase

        store_word = word;
        case (funct3)
            F3_B:    store_word[{offset, 3'b000} +: 8]     = store_data[7:0];
            F3_H:    store_word[{offset[1], 4'b0000} +: 16] = store_data[15:0];
            default: store_word = store_data;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Initiator for a word-wide data memory: byte/half/word loads and stores,
// sub-word stores done as read-modify-write, one request in flight.
module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    mau_state_t        state, next_state;
    logic              we_q;
    logic [2:0]        funct3_q;
    logic [1:0]        offset_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              accept;
    logic              legal;
    logic [31:0]       load_data;
    logic [31:0]       store_word;

    assign accept = req_valid && req_ready;
    assign legal  = req_legal(req_we, req_funct3, req_addr[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (!legal)                            next_state = RESP;
                    else if (req_we && req_funct3 == F3_W) next_state = WR;
                    else                                   next_state = RD;
                end
            end
            RD:      next_state = we_q ? WR : RESP;
            WR:      next_state = RESP;
            RESP:    if (resp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // wdata_q carries raw store data until RD, then the merged word for WR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q     <= 1'b0;
            funct3_q <= '0;
            offset_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else if (accept) begin
            we_q     <= req_we;
            funct3_q <= req_funct3;
            offset_q <= req_addr[1:0];
            addr_q   <= {req_addr[ADDR_W-1:2], 2'b00};
            wdata_q  <= (req_we && legal) ? req_wdata : 32'd0;
            rdata_q  <= '0;
            err_q    <= !legal;
        end else if (state == RD) begin
            if (we_q) wdata_q <= store_word;
            else      rdata_q <= load_data;
        end
    end

    mau_lane_align u_lane_align (
        .word       (mem_rdata),
        .offset     (offset_q),
        .funct3     (funct3_q),
        .store_data (wdata_q),
        .load_data  (load_data),
        .store_word (store_word)
    );

    // Strobes decode directly from the state flop, so they are glitch-free
    // around the memory's falling-edge sample and clear with async reset.
    assign req_ready  = rst_n && (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_err   = err_q;
    assign resp_rdata = rdata_q;
    assign mem_ren    = (state == RD);
    assign mem_wen    = (state == WR);
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a word memory model that writes on
// the falling edge and reads combinationally.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] mem [64];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr[7:2]];

    always @(negedge clk) begin
        if (mem_wen) mem[mem_addr[7:2]] = mem_wdata;
    end

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_ren    (mem_ren),
        .mem_wen    (mem_wen),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] pre;
        logic [31:0] rdata;
        logic        err;
        int          lat;
        int          rd;
        int          wr;
        logic [31:0] post;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input string what,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h, expected %h", name, what, act, exp);
        end
    endtask

    // Issue one request with resp_ready high and check timing, strobes and result.
    task automatic run_req(input string name, input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] rdata_e, input logic err_e,
                           input int lat_e, input int rd_e, input int wr_e);
        int lat, rd, wr, both;
        logic [31:0] seen;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        resp_ready = 1'b1;
        chk(name, "req_ready", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        lat = 0; rd = 0; wr = 0; both = 0;
        seen = 32'hFFFF_FFFF;
        for (int k = 1; k <= 10; k++) begin
            if (mem_ren) rd++;
            if (mem_wen) wr++;
            if (mem_ren && mem_wen) both++;
            if (mem_ren || mem_wen) seen = mem_addr;
            if (resp_valid) begin
                lat = k;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk(name, "latency", 32'(lat), 32'(lat_e));
        chk(name, "ren_cycles", 32'(rd), 32'(rd_e));
        chk(name, "wen_cycles", 32'(wr), 32'(wr_e));
        chk(name, "ren_wen_overlap", 32'(both), 32'd0);
        chk(name, "mem_addr", seen,
            (rd_e + wr_e > 0) ? {addr[31:2], 2'b00} : 32'hFFFF_FFFF);
        chk(name, "resp_rdata", resp_rdata, rdata_e);
        chk(name, "resp_err", 32'(resp_err), 32'(err_e));
        @(posedge clk);
        #1;
        chk(name, "resp_valid_after", 32'(resp_valid), 32'd0);
        chk(name, "req_ready_after", 32'(req_ready), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk(name, "req_ready", 32'(req_ready), 32'd0);
        chk(name, "resp_valid", 32'(resp_valid), 32'd0);
        chk(name, "resp_err", 32'(resp_err), 32'd0);
        chk(name, "resp_rdata", resp_rdata, 32'd0);
        chk(name, "mem_ren", 32'(mem_ren), 32'd0);
        chk(name, "mem_wen", 32'(mem_wen), 32'd0);
        chk(name, "mem_addr", mem_addr, 32'd0);
        chk(name, "mem_wdata", mem_wdata, 32'd0);
    endtask

    initial begin
        int k;
        logic seen_v;
        vecs[0]  = '{1'b0, 3'b010, 32'h10, 32'h0,        32'h8899AABB, 32'h8899AABB, 1'b0, 2, 1, 0, 32'h8899AABB};
        vecs[1]  = '{1'b0, 3'b000, 32'h13, 32'h0,        32'h80123456, 32'hFFFFFF80, 1'b0, 2, 1, 0, 32'h80123456};
        vecs[2]  = '{1'b0, 3'b100, 32'h13, 32'h0,        32'h80123456, 32'h00000080, 1'b0, 2, 1, 0, 32'h80123456};
        vecs[3]  = '{1'b0, 3'b001, 32'h12, 32'h0,        32'h80011234, 32'hFFFF8001, 1'b0, 2, 1, 0, 32'h80011234};
        vecs[4]  = '{1'b0, 3'b101, 32'h12, 32'h0,        32'h80011234, 32'h00008001, 1'b0, 2, 1, 0, 32'h80011234};
        vecs[5]  = '{1'b0, 3'b000, 32'h11, 32'h0,        32'h12345678, 32'h00000056, 1'b0, 2, 1, 0, 32'h12345678};
        vecs[6]  = '{1'b0, 3'b001, 32'h10, 32'h0,        32'h1234F678, 32'hFFFFF678, 1'b0, 2, 1, 0, 32'h1234F678};
        vecs[7]  = '{1'b0, 3'b101, 32'h1A, 32'h0,        32'hABCD0000, 32'h0000ABCD, 1'b0, 2, 1, 0, 32'hABCD0000};
        vecs[8]  = '{1'b1, 3'b000, 32'h21, 32'hFFFFFF5A, 32'h11223344, 32'h0,        1'b0, 3, 1, 1, 32'h11225A44};
        vecs[9]  = '{1'b1, 3'b001, 32'h22, 32'h1234BEEF, 32'h11223344, 32'h0,        1'b0, 3, 1, 1, 32'hBEEF3344};
        vecs[10] = '{1'b1, 3'b010, 32'h24, 32'hCAFEF00D, 32'h0,        32'h0,        1'b0, 2, 0, 1, 32'hCAFEF00D};
        vecs[11] = '{1'b0, 3'b010, 32'h06, 32'h0,        32'hDEADBEEF, 32'h0,        1'b1, 1, 0, 0, 32'hDEADBEEF};
        vecs[12] = '{1'b1, 3'b001, 32'h03, 32'h0000FFFF, 32'h01020304, 32'h0,        1'b1, 1, 0, 0, 32'h01020304};
        vecs[13] = '{1'b1, 3'b100, 32'h28, 32'h000000FF, 32'h55555555, 32'h0,        1'b1, 1, 0, 0, 32'h55555555};
        vecs[14] = '{1'b0, 3'b011, 32'h2C, 32'h0,        32'h66666666, 32'h0,        1'b1, 1, 0, 0, 32'h66666666};
        vecs[15] = '{1'b0, 3'b001, 32'h11, 32'h0,        32'h77777777, 32'h0,        1'b1, 1, 0, 0, 32'h77777777};

        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        resp_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("reset_release", "req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            mem[vecs[i].addr[7:2]] = vecs[i].pre;
            run_req($sformatf("vec%0d", i), vecs[i].we, vecs[i].f3, vecs[i].addr,
                    vecs[i].wdata, vecs[i].rdata, vecs[i].err,
                    vecs[i].lat, vecs[i].rd, vecs[i].wr);
            chk($sformatf("vec%0d", i), "mem_word", mem[vecs[i].addr[7:2]], vecs[i].post);
        end

        // Response held off by resp_ready low for five cycles.
        @(negedge clk);
        mem[12]    = 32'h0BADF00D;
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h30;
        req_wdata  = 32'd0;
        resp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        seen_v = 1'b0;
        for (k = 0; k < 10; k++) begin
            if (resp_valid) begin
                seen_v = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("hold", "resp_seen", 32'(seen_v), 32'd1);
        for (int c = 0; c < 5; c++) begin
            chk("hold", "resp_valid", 32'(resp_valid), 32'd1);
            chk("hold", "resp_rdata", resp_rdata, 32'h0BADF00D);
            chk("hold", "req_ready", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_release", "resp_valid", 32'(resp_valid), 32'd0);
        chk("hold_release", "req_ready", 32'(req_ready), 32'd1);

        // Reset asserted during the WR cycle of an SH, before the falling edge.
        @(negedge clk);
        mem[16]    = 32'h12345678;
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b001;
        req_addr   = 32'h42;
        req_wdata  = 32'h0000AAAA;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        seen_v = 1'b0;
        for (k = 0; k < 10; k++) begin
            if (mem_wen) begin
                seen_v = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("rst_wr", "wen_seen", 32'(seen_v), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_wr");
        @(negedge clk);
        #1;
        chk("rst_wr", "mem_word", mem[16], 32'h12345678);
        @(negedge clk);
        rst_n = 1'b1;
        run_req("post_reset_lw", 1'b0, 3'b010, 32'h40, 32'h0, 32'h12345678, 1'b0, 2, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
